// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: behavioural line-memory slave for a 4-beat x 64-bit
// burst bus. A request is accepted in IDLE, answered LATENCY cycles later
// with four consecutive resp beats, followed by one DONE turnaround cycle.
// Optional macro PMEM_PROTOCOL_CHECK_EN builds a sticky protocol checker
// driving proto_err; without it proto_err is tied low.
module pmem_burst_responder #(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err
);
  localparam int unsigned LW     = $clog2(DEPTH_LINES);
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    beat_q, beat_d;
  logic          op_rd_q, op_rd_d;
  logic [LW-1:0] line_q, line_d;
  logic          req;

  // Backing store: line-major, 4 words per line; deliberately not reset.
  logic [63:0]   mem_q [DEPTH_LINES*4];

  // Address bits outside the line index only matter to the optional checker.
  logic unused_addr;
  assign unused_addr = ^{pmem_address[31:5+LW], pmem_address[4:0]};

  assign req = pmem_read | pmem_write;

  // Control registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      op_rd_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      op_rd_q <= op_rd_d;
      line_q  <= line_d;
    end
  end

  // Next state: WAIT spans LATENCY-1 cycles so beat 0 lands LATENCY cycles
  // after the acceptance edge; LATENCY==1 skips WAIT entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    op_rd_d = op_rd_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_rd_d = pmem_read;  // read wins when both are high
          line_d  = pmem_address[5 +: LW];
          cnt_d   = LAT_M1;
          beat_d  = '0;
          state_d = (LATENCY == 1) ? BURST : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = BURST;
      end
      BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write beat commits at the edge ending its resp cycle, unless reset hits it.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == BURST && !op_rd_q)
      mem_q[{line_q, beat_q}] <= pmem_wdata;
  end

  assign pmem_resp  = (state_q == BURST);
  assign pmem_rdata = (state_q == BURST && op_rd_q) ? mem_q[{line_q, beat_q}] : 64'd0;

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [15:0] base_q, base_d;
  logic        perr_q, perr_d;
  logic        busy;

  assign busy = (state_q == WAIT) || (state_q == BURST);

  // Checker registers: address snapshot and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q <= '0;
      perr_q <= 1'b0;
    end else begin
      base_q <= base_d;
      perr_q <= perr_d;
    end
  end

  // Violation detection: dual request, early drop, address drift, op flip.
  always_comb begin
    base_d = base_q;
    perr_d = perr_q;
    if (state_q == IDLE && req) base_d = pmem_address[15:0];
    if (state_q == IDLE && pmem_read && pmem_write) perr_d = 1'b1;
    if (busy) begin
      if ((op_rd_q ? !pmem_read : !pmem_write) &&
          (state_q == WAIT || beat_q != 2'd3)) perr_d = 1'b1;
      if (op_rd_q ? pmem_write : pmem_read) perr_d = 1'b1;
      if (pmem_address[15:0] != base_q) perr_d = 1'b1;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule
